bigram_counter: RTL and testbench

- Downstream consumer of the 3-bit symbol register stage.
- Receives a stream of 3-bit symbol codes, forms (previous, current) pairs and accumulates a 64-bin bigram histogram in a register array, one count per pair.
- After a counting run, the host reads the histogram bin by bin.
- Feeds the feature/score stages of the NLP accelerator.

---
 rtl/bigram_pkg.sv | 25 ++
 rtl/bigram_counter_if.sv | 35 +++
 rtl/bigram_counter_sat_inc.sv | 15 +
 rtl/bigram_counter.sv | 156 +++++++++++++++
 tb/tb_bigram_counter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/bigram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : bigram_pkg                                               |
// | Brief   : Shared constants, state encoding and bin-index helper.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package bigram_pkg;

   localparam int SYM_W    = 3;
   localparam int BIN_W    = 2 * SYM_W;
   localparam int NUM_BINS = 64;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      COUNT = 2'd2
   } state_t;

   function automatic logic [BIN_W-1:0] bin_idx(input logic [SYM_W-1:0] prev,
                                                input logic [SYM_W-1:0] cur);
      return {prev, cur};
   endfunction

endpackage
`default_nettype wire

// File: rtl/bigram_counter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : bigram_counter_if                                        |
// | Brief   : Symbol/control/readout bundle between host and counter.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface bigram_counter_if
   import bigram_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int TOT_W = 16
);
   logic             sym_valid;
   logic [SYM_W-1:0] sym_in;
   logic             start;
   logic             stop;
   logic             clear;
   logic             rd_en;
   logic [BIN_W-1:0] rd_addr;
   logic [CNT_W-1:0] rd_data;
   logic             rd_valid;
   logic             busy;
   logic [TOT_W-1:0] total_pairs;

   modport master (
      output sym_valid, sym_in, start, stop, clear, rd_en, rd_addr,
      input  rd_data, rd_valid, busy, total_pairs
   );

   modport slave (
      input  sym_valid, sym_in, start, stop, clear, rd_en, rd_addr,
      output rd_data, rd_valid, busy, total_pairs
   );
endinterface
`default_nettype wire

// File: rtl/bigram_counter_sat_inc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sat_inc                                                  |
// | Brief   : Parameterised saturating +1 incrementer.                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sat_inc #(
   parameter int W = 8
) (
   input  wire logic [W-1:0] i_val,
   output logic      [W-1:0] o_val
);
   assign o_val = (&i_val) ? i_val : i_val + W'(1);
endmodule
`default_nettype wire

// File: rtl/bigram_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : bigram_counter                                           |
// | Brief   : 64-bin (prev,cur) symbol-pair histogram with host read.  |
// |           BIGRAM_CLR_ON_RD_EN: IDLE reads also zero the bin.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module bigram_counter
   import bigram_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int TOT_W = 16
) (
   input  wire logic        clock,
   input  wire logic        rst,
   bigram_counter_if.slave  bus
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [BIN_W-1:0] r_clr_ptr;
   logic             r_have_prev;
   logic [SYM_W-1:0] r_prev;
   logic [CNT_W-1:0] r_bin [NUM_BINS];
   logic [CNT_W-1:0] r_rd_data;
   logic             r_rd_valid;
   logic [TOT_W-1:0] r_total;

   logic             w_sym_take;
   logic             w_pair;
   logic             w_rd_take;
   logic [BIN_W-1:0] w_pair_idx;
   logic [CNT_W-1:0] w_bin_cur;
   logic [CNT_W-1:0] w_bin_inc;
   logic [TOT_W-1:0] w_tot_inc;
   logic             w_we;
   logic [BIN_W-1:0] w_waddr;
   logic [CNT_W-1:0] w_wdata;

   assign w_sym_take = (r_state == COUNT) && bus.sym_valid;
   assign w_pair     = w_sym_take && r_have_prev;
   assign w_rd_take  = (r_state == IDLE) && bus.rd_en;
   assign w_pair_idx = bin_idx(r_prev, bus.sym_in);
   assign w_bin_cur  = r_bin[w_pair_idx];

   sat_inc #(.W(CNT_W)) u_bin_inc (
      .i_val (w_bin_cur),
      .o_val (w_bin_inc)
   );

   sat_inc #(.W(TOT_W)) u_tot_inc (
      .i_val (r_total),
      .o_val (w_tot_inc)
   );

   always_ff @(posedge clock) begin
      if (rst) begin
         r_state <= CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Single shared write port: CLEAR sweep, COUNT increment, optional read-clear.
   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      w_waddr     = r_clr_ptr;
      w_wdata     = '0;
      case (r_state)
         CLEAR: begin
            w_we    = 1'b1;
            w_waddr = r_clr_ptr;
            if (&r_clr_ptr) begin
               w_state_nxt = IDLE;
            end
         end
         IDLE: begin
            if (bus.start) begin
               w_state_nxt = COUNT;
            end else if (bus.clear) begin
               w_state_nxt = CLEAR;
            end
`ifdef BIGRAM_CLR_ON_RD_EN
            if (bus.rd_en) begin
               w_we    = 1'b1;
               w_waddr = bus.rd_addr;
            end
`endif
         end
         COUNT: begin
            if (w_pair) begin
               w_we    = 1'b1;
               w_waddr = w_pair_idx;
               w_wdata = w_bin_inc;
            end
            if (bus.stop) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clock) begin
      if (w_we) begin
         r_bin[w_waddr] <= w_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         r_clr_ptr   <= '0;
         r_have_prev <= 1'b0;
         r_prev      <= '0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_total     <= '0;
      end else begin
         r_rd_valid <= w_rd_take;
         if (w_rd_take) begin
            r_rd_data <= r_bin[bus.rd_addr];
         end
         case (r_state)
            CLEAR: begin
               r_clr_ptr <= r_clr_ptr + BIN_W'(1);
               r_total   <= '0;
            end
            IDLE: begin
               if (bus.start) begin
                  r_have_prev <= 1'b0;
               end else if (bus.clear) begin
                  r_clr_ptr <= '0;
               end
            end
            COUNT: begin
               if (w_sym_take) begin
                  r_prev      <= bus.sym_in;
                  r_have_prev <= 1'b1;
               end
               if (w_pair) begin
                  r_total <= w_tot_inc;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rd_data     = r_rd_data;
   assign bus.rd_valid    = r_rd_valid;
   assign bus.busy        = (r_state != IDLE);
   assign bus.total_pairs = r_total;

endmodule
`default_nettype wire

// File: tb/tb_bigram_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_bigram_counter                                        |
// | Brief   : Directed self-checking bench for bigram_counter.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_bigram_counter;
   import bigram_pkg::*;

   logic clock = 1'b0;
   logic rst   = 1'b1;
   int   total = 0;
   int   bad   = 0;

   bigram_counter_if #(.CNT_W(8), .TOT_W(16)) bus ();

   bigram_counter #(.CNT_W(8), .TOT_W(16)) u_dut (
      .clock (clock),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [2:0] s);
      bus.sym_valid = 1'b1;
      bus.sym_in    = s;
      tick();
      bus.sym_valid = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk(tag, n, 64);
   endtask

   task automatic do_clear(input string tag);
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      wait_idle(tag);
   endtask

   task automatic read_bin(input string tag, input logic [5:0] a, input logic [7:0] exp);
      bus.rd_en   = 1'b1;
      bus.rd_addr = a;
      tick();
      bus.rd_en = 1'b0;
      chk({tag, "_vld"}, bus.rd_valid, 1);
      chk(tag, bus.rd_data, exp);
   endtask

   // Back-to-back sweep of every bin; returns sum of counts and count of missing valids.
   task automatic sweep(output int sum, output int novld);
      sum   = 0;
      novld = 0;
      for (int a = 0; a < NUM_BINS; a++) begin
         bus.rd_en   = 1'b1;
         bus.rd_addr = 6'(a);
         tick();
         if (bus.rd_valid !== 1'b1) novld++;
         sum += int'(bus.rd_data);
      end
      bus.rd_en = 1'b0;
   endtask

   initial begin
      int sum;
      int novld;
      bus.sym_valid = 1'b0;
      bus.sym_in    = '0;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.clear     = 1'b0;
      bus.rd_en     = 1'b0;
      bus.rd_addr   = '0;

      // Reset state
      tick();
      tick();
      chk("rst_busy", bus.busy, 1);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_total", bus.total_pairs, 0);
      rst = 1'b0;
      wait_idle("rst_clear_len");
      sweep(sum, novld);
      chk("init_sum", sum, 0);
      chk("init_novld", novld, 0);
      tick();
      chk("rd_valid_drop", bus.rd_valid, 0);

      // Run 1,2,3,1,2
      pulse_start();
      chk("count_busy", bus.busy, 1);
      send(3'd1); send(3'd2); send(3'd3); send(3'd1); send(3'd2);
      pulse_stop();
      chk("r1_idle", bus.busy, 0);
      chk("r1_total", bus.total_pairs, 4);
      read_bin("r1_b10", 6'd10, 8'd2);
      read_bin("r1_b19", 6'd19, 8'd1);
      read_bin("r1_b25", 6'd25, 8'd1);
      read_bin("r1_b9", 6'd9, 8'd0);
      sweep(sum, novld);
      chk("r1_sum", sum, 4);

      // Back-to-back read of bin 10
      bus.rd_en   = 1'b1;
      bus.rd_addr = 6'd10;
      tick();
      chk("b2b_first", bus.rd_data, 2);
      tick();
      bus.rd_en = 1'b0;
      chk("b2b_vld", bus.rd_valid, 1);
`ifdef BIGRAM_CLR_ON_RD_EN
      chk("b2b_second", bus.rd_data, 0);
`else
      chk("b2b_second", bus.rd_data, 2);
`endif
      chk("b2b_total", bus.total_pairs, 4);

      // Clear, then two runs with no cross-run pair
      do_clear("clr1_len");
      chk("clr1_total", bus.total_pairs, 0);
      read_bin("clr1_b19", 6'd19, 8'd0);
      pulse_start();
      send(3'd7); send(3'd7); send(3'd7); send(3'd7);
      pulse_stop();
      read_bin("r2_b63", 6'd63, 8'd3);
      pulse_start();
      send(3'd7); send(3'd0);
      pulse_stop();
      read_bin("r3_b63", 6'd63, 8'd3);
      read_bin("r3_b56", 6'd56, 8'd1);
      chk("r3_total", bus.total_pairs, 4);

      // Saturation: 300 consecutive symbol-4 pulses
      do_clear("clr2_len");
      pulse_start();
      bus.sym_valid = 1'b1;
      bus.sym_in    = 3'd4;
      for (int i = 0; i < 300; i++) tick();
      bus.sym_valid = 1'b0;
      pulse_stop();
      read_bin("sat_b36", 6'd36, 8'd255);
      chk("sat_total", bus.total_pairs, 299);
      do_clear("clr3_len");
      read_bin("clr3_b36", 6'd36, 8'd0);

      // Stop with last symbol; reads during COUNT ignored
      pulse_start();
      send(3'd2);
      bus.rd_en   = 1'b1;
      bus.rd_addr = 6'd36;
      bus.sym_valid = 1'b1;
      bus.sym_in    = 3'd3;
      tick();
      chk("cnt_rd_valid", bus.rd_valid, 0);
      bus.sym_in = 3'd2;
      bus.stop   = 1'b1;
      tick();
      bus.sym_valid = 1'b0;
      bus.stop      = 1'b0;
      bus.rd_en     = 1'b0;
      chk("cnt_rd_valid2", bus.rd_valid, 0);
      chk("stop_idle", bus.busy, 0);
      read_bin("r4_b19", 6'd19, 8'd1);
      read_bin("r4_b26", 6'd26, 8'd1);
      chk("r4_total", bus.total_pairs, 2);

      // start+clear together: start wins, histogram kept
      bus.start = 1'b1;
      bus.clear = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.clear = 1'b0;
      chk("sc_busy", bus.busy, 1);
      pulse_stop();
      chk("sc_idle", bus.busy, 0);
      read_bin("sc_b26", 6'd26, 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
